// File: rtl/xor_fold_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xor_fold_pkg : shared widths, fold helper and tag-width helper    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package xor_fold_pkg;

   localparam int IN_W_DEF  = 32;
   localparam int OUT_W_DEF = 16;

   // Requester tag width: clog2 of the requester count, never below one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [OUT_W_DEF-1:0] fold(input logic [IN_W_DEF-1:0] x);
      return x[IN_W_DEF-1:OUT_W_DEF] ^ x[OUT_W_DEF-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/xor_fold_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xor_fold_unit : combinational upper^lower fold of two operands   |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module xor_fold_unit
   import xor_fold_pkg::*;
#(
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic [2*OUT_W-1:0] a,
   input  logic [2*OUT_W-1:0] b,
   output logic [OUT_W-1:0]   aa,
   output logic [OUT_W-1:0]   bb
);

   for (genvar g = 0; g < OUT_W; g++) begin : g_cell
      assign aa[g] = a[g+OUT_W] ^ a[g];
      assign bb[g] = b[g+OUT_W] ^ b[g];
   end

endmodule
`default_nettype wire

// File: rtl/xor_fold_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xor_fold_arbiter : round-robin share of one XOR-fold datapath    |
// | feeding a 2-entry tagged output FIFO.         Revision 1.0       |
// +------------------------------------------------------------------+
module xor_fold_arbiter
   import xor_fold_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IN_W    = IN_W_DEF,
   parameter int OUT_W   = OUT_W_DEF,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*IN_W-1:0] req_a,
   input  logic [NUM_REQ*IN_W-1:0] req_b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_aa,
   output logic [OUT_W-1:0]        out_bb,
   output logic [ID_W-1:0]         out_id
);

   localparam logic [ID_W:0]   NUM_C    = NUM_REQ[ID_W:0];
   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_any;
   logic [ID_W:0]    cand;
   logic             space;
   logic             push;
   logic             pop;
   logic [IN_W-1:0]  sel_a;
   logic [IN_W-1:0]  sel_b;
   logic [OUT_W-1:0] fold_aa;
   logic [OUT_W-1:0] fold_bb;

   logic [OUT_W-1:0] mem_aa [2];
   logic [OUT_W-1:0] mem_bb [2];
   logic [ID_W-1:0]  mem_id [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;

   assign out_valid = (count != 2'd0);
   assign pop       = out_valid & out_ready;
   assign space     = (count < 2'd2) | pop;

   // Scan downward so the candidate closest to ptr (smallest offset) wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      if (space && !rst) begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + k[ID_W:0];
            if (cand >= NUM_C) cand = cand - NUM_C;
            if (req_valid[cand[ID_W-1:0]]) begin
               grant_any = 1'b1;
               grant_idx = cand[ID_W-1:0];
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_any) req_ready[grant_idx] = 1'b1;
   end

   assign push  = grant_any;
   assign sel_a = req_a[grant_idx*IN_W +: IN_W];
   assign sel_b = req_b[grant_idx*IN_W +: IN_W];

   xor_fold_unit #(.OUT_W(OUT_W)) u_fold (
      .a  (sel_a),
      .b  (sel_b),
      .aa (fold_aa),
      .bb (fold_bb)
   );

   // When full, a push only happens alongside a pop, so wr_ptr==rd_ptr is safe to overwrite.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         for (int e = 0; e < 2; e++) begin
            mem_aa[e] <= '0;
            mem_bb[e] <= '0;
            mem_id[e] <= '0;
         end
      end else begin
         if (push) begin
            mem_aa[wr_ptr] <= fold_aa;
            mem_bb[wr_ptr] <= fold_bb;
            mem_id[wr_ptr] <= grant_idx;
            wr_ptr         <= ~wr_ptr;
            ptr            <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign out_aa = mem_aa[rd_ptr];
   assign out_bb = mem_bb[rd_ptr];
   assign out_id = mem_id[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_xor_fold_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_xor_fold_arbiter : directed scoreboard bench for the arbiter  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_xor_fold_arbiter;

   localparam int N = 4;

   typedef struct packed {
      logic [15:0] aa;
      logic [15:0] bb;
      logic [1:0]  id;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_ready;
   logic [N*32-1:0] req_a;
   logic [N*32-1:0] req_b;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [15:0]   out_aa;
   logic [15:0]   out_bb;
   logic [1:0]    out_id;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   // Hand-folded results per requester for the operand table below.
   logic [15:0] exp_aa_tab [N] = '{16'h0001, 16'hFFFF, 16'h444C, 16'hABCD};
   logic [15:0] exp_bb_tab [N] = '{16'h0010, 16'h0000, 16'h0000, 16'hBEEF};

   always #5 clk = ~clk;

   xor_fold_arbiter #(.NUM_REQ(N), .IN_W(32), .OUT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_aa    (out_aa),
      .out_bb    (out_bb),
      .out_id    (out_id)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // g: expected granted requester (-1 none); ov: expected out_valid (2 = unchecked)
   task automatic step(input logic [3:0] v, input logic ordy, input int g, input int ov);
      exp_t e;
      req_valid = v;
      out_ready = ordy;
      @(negedge clk);
      chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      if (ov != 2) chk("out_valid", 32'(out_valid), 32'(ov));
      if (g >= 0) begin
         e.aa = exp_aa_tab[g];
         e.bb = exp_bb_tab[g];
         e.id = g[1:0];
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [3:0] v);
      rst       = 1'b1;
      req_valid = v;
      out_ready = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("rst_req_ready_pre", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_aa", 32'(out_aa), 32'd0);
      chk("rst_out_bb", 32'(out_bb), 32'd0);
      chk("rst_out_id", 32'(out_id), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: every accepted output must match the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got id %0d expected none", out_id);
         end else begin
            e = sb.pop_front();
            chk("out_aa", 32'(out_aa), 32'(e.aa));
            chk("out_bb", 32'(out_bb), 32'(e.bb));
            chk("out_id", 32'(out_id), 32'(e.id));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      req_a = {32'hABCD0000, 32'h12345678, 32'hFFFF0000, 32'h00010000};
      req_b = {32'h0000BEEF, 32'hA5A5A5A5, 32'h12341234, 32'h00000010};
      do_reset(4'b0000);

      // Single requester latency
      step(4'b0100, 1'b1, 2, 0);
      step(4'b0000, 1'b1, -1, 1);
      step(4'b0000, 1'b1, -1, 0);

      // All valid, full throughput round robin from ptr=0
      do_reset(4'b0000);
      step(4'b1111, 1'b1, 0, 0);
      step(4'b1111, 1'b1, 1, 1);
      step(4'b1111, 1'b1, 2, 1);
      step(4'b1111, 1'b1, 3, 1);
      step(4'b1111, 1'b1, 0, 1);
      step(4'b1111, 1'b1, 1, 1);
      step(4'b1111, 1'b1, 2, 1);
      step(4'b1111, 1'b1, 3, 1);
      step(4'b0000, 1'b1, -1, 1);

      // Backpressure: two transfers then stall with a stable head
      step(4'b1111, 1'b0, 0, 0);
      step(4'b1111, 1'b0, 1, 1);
      step(4'b1111, 1'b0, -1, 1);
      chk("head_id", 32'(out_id), 32'd0);
      chk("head_aa", 32'(out_aa), 32'h0001);
      step(4'b1111, 1'b0, -1, 1);
      chk("head_id_hold", 32'(out_id), 32'd0);
      chk("head_bb_hold", 32'(out_bb), 32'h0010);
      step(4'b1111, 1'b1, 2, 1);
      step(4'b1111, 1'b1, 3, 1);
      step(4'b0000, 1'b1, -1, 1);
      step(4'b0000, 1'b1, -1, 1);

      // Push and pop together while full
      step(4'b0001, 1'b0, 0, 0);
      step(4'b0001, 1'b0, 0, 1);
      step(4'b0010, 1'b1, 1, 1);
      step(4'b0000, 1'b1, -1, 1);
      step(4'b0000, 1'b1, -1, 1);

      // Sparse requests with wrap, ptr brought to 1 first
      step(4'b0001, 1'b1, 0, 0);
      step(4'b1001, 1'b1, 3, 1);
      step(4'b0001, 1'b1, 0, 1);
      step(4'b1111, 1'b1, 1, 1);
      step(4'b0000, 1'b1, -1, 1);

      // Reset with the FIFO full discards its contents
      step(4'b1111, 1'b0, 2, 0);
      step(4'b1111, 1'b0, 3, 1);
      step(4'b1111, 1'b0, -1, 1);
      do_reset(4'b1111);
      step(4'b1100, 1'b1, 2, 0);
      step(4'b0000, 1'b1, -1, 1);
      step(4'b0000, 1'b1, -1, 0);

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
